// File: rtl/axil_init_seq_pkg.sv
// Shared types for the AXI-Lite init sequencer: command opcodes, table entry layout, FSM states.
package axil_init_seq_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_POLL  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } op_t;

  typedef struct packed {
    op_t                   op;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_DATA_W-1:0] mask;
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR,
    ST_WR_B,
    ST_RD,
    ST_RD_R,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle with master/slave modports; protection and strobes carried for fabric compatibility.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_init_seq.sv
// Boot master walking CMD_TABLE (write / read-poll / delay); one request in flight, 4-cycle write or poll with zero-wait slave, valids held until ready.
// AXIL_INIT_SEQ_RESP_CHECK_EN: a non-OKAY bresp/rresp aborts to ERROR; otherwise response codes are ignored.
module axil_init_seq
  import axil_init_seq_pkg::*;
#(
  parameter int   AXIL_ADDR_WIDTH     = 32,
  parameter int   AXIL_DATA_WIDTH     = 32,
  parameter int   CMD_NUM             = 8,
  parameter cmd_t CMD_TABLE [CMD_NUM] = '{default: '0},
  parameter int   POLL_LIMIT          = 1024,
  parameter bit   AUTO_START          = 1'b1,
  localparam int  IDX_W               = (CMD_NUM > 1) ? $clog2(CMD_NUM) : 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W-1:0] err_idx_o,
  axil_if.master           m_axil
);

  // idx must be able to hold CMD_NUM itself to detect running off the table end
  localparam int          POS_W = $clog2(CMD_NUM + 1);
  localparam logic [31:0] LIMIT = 32'(POLL_LIMIT);

  state_t                   state;
  logic [POS_W-1:0]         idx;
  logic [CMD_ADDR_W-1:0]    cmd_addr;
  logic [CMD_DATA_W-1:0]    cmd_data;
  logic [CMD_DATA_W-1:0]    cmd_mask;
  logic [31:0]              cnt;
  logic                     awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  cmd_t                     fetch_cmd;
  logic                     poll_hit, b_err, r_err, go_err;

  assign fetch_cmd = CMD_TABLE[idx[IDX_W-1:0]];
  assign poll_hit  = ((m_axil.rdata ^ cmd_data[AXIL_DATA_WIDTH-1:0])
                      & cmd_mask[AXIL_DATA_WIDTH-1:0]) == '0;

`ifdef AXIL_INIT_SEQ_RESP_CHECK_EN
  assign b_err = m_axil.bresp != RESP_OKAY;
  assign r_err = m_axil.rresp != RESP_OKAY;
`else
  assign b_err = 1'b0;
  assign r_err = 1'b0;
`endif

  // cnt doubles as the poll attempt counter while in RD/RD_R
  assign go_err = (state == ST_WR_B && m_axil.bvalid && b_err) ||
                  (state == ST_RD_R && m_axil.rvalid &&
                   (r_err || (!poll_hit && (cnt + 32'd1 >= LIMIT))));

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_mask  <= '0;
      cnt       <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      err_idx_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i || (state == ST_IDLE && AUTO_START)) begin
            idx     <= '0;
            cnt     <= '0;
            busy_o  <= 1'b1;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          cmd_addr <= fetch_cmd.addr;
          cmd_data <= fetch_cmd.data;
          cmd_mask <= fetch_cmd.mask;
          cnt      <= '0;
          if (idx == POS_W'(CMD_NUM) || fetch_cmd.op == OP_END) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= ST_DONE;
          end else begin
            case (fetch_cmd.op)
              OP_WRITE: begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state     <= ST_WR;
              end
              OP_POLL: begin
                arvalid_q <= 1'b1;
                state     <= ST_RD;
              end
              default: begin
                cnt   <= {8'd0, fetch_cmd.data[23:0]};
                state <= ST_DELAY;
              end
            endcase
          end
        end
        ST_WR: begin
          if (m_axil.awready) awvalid_q <= 1'b0;
          if (m_axil.wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axil.awready) && (!wvalid_q || m_axil.wready)) begin
            bready_q <= 1'b1;
            state    <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m_axil.bvalid) begin
            bready_q <= 1'b0;
            state    <= ST_NEXT;
          end
        end
        ST_RD: begin
          if (m_axil.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (m_axil.rvalid) begin
            rready_q <= 1'b0;
            if (poll_hit) begin
              state <= ST_NEXT;
            end else begin
              cnt       <= cnt + 32'd1;
              arvalid_q <= 1'b1;
              state     <= ST_RD;
            end
          end
        end
        ST_DELAY: begin
          if (cnt == '0) state <= ST_NEXT;
          else           cnt   <= cnt - 32'd1;
        end
        ST_NEXT: begin
          idx   <= idx + 1'b1;
          cnt   <= '0;
          state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase

      // Abort overrides whatever the state branch scheduled, including a poll retry
      if (go_err) begin
        arvalid_q <= 1'b0;
        error_o   <= 1'b1;
        busy_o    <= 1'b0;
        err_idx_o <= idx[IDX_W-1:0];
        state     <= ST_ERROR;
      end
    end
  end

  assign m_axil.awaddr  = cmd_addr[AXIL_ADDR_WIDTH-1:0];
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = cmd_data[AXIL_DATA_WIDTH-1:0];
  assign m_axil.wstrb   = '1;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = cmd_addr[AXIL_ADDR_WIDTH-1:0];
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule

// File: tb/tb_axil_init_seq.sv
// Directed bench: auto-start DUT on a short write table, manual-start DUT on a write/delay/poll table with a scripted slave.
`timescale 1ns/1ps
module tb_axil_init_seq;
  import axil_init_seq_pkg::*;

  localparam cmd_t TBL_A [3] = '{
    cmd_t'{OP_WRITE, 32'h0000_0004, 32'h0000_01B2, 32'h0},
    cmd_t'{OP_WRITE, 32'h0001_0000, 32'h0000_0005, 32'h0},
    cmd_t'{OP_END,   32'h0,         32'h0,         32'h0}
  };
  localparam cmd_t TBL_B [8] = '{
    cmd_t'{OP_WRITE, 32'h0000_0004, 32'h0000_01B2, 32'h0},
    cmd_t'{OP_WRITE, 32'h0001_0000, 32'h0000_0005, 32'h0},
    cmd_t'{OP_WRITE, 32'h0000_000C, 32'h0000_00AA, 32'h0},
    cmd_t'{OP_DELAY, 32'h0,         32'd100,       32'h0},
    cmd_t'{OP_WRITE, 32'h0000_0020, 32'h0000_0055, 32'h0},
    cmd_t'{OP_POLL,  32'h0000_0008, 32'h0000_0001, 32'h1},
    cmd_t'{OP_END,   32'h0,         32'h0,         32'h0},
    cmd_t'{OP_END,   32'h0,         32'h0,         32'h0}
  };

  logic       clk_i = 1'b0;
  logic       arstn_i = 1'b0;
  logic       a_start = 1'b0, b_start = 1'b0;
  logic       a_busy, a_done, a_error;
  logic [1:0] a_err_idx;
  logic       b_busy, b_done, b_error;
  logic [2:0] b_err_idx;

  always #5 clk_i = ~clk_i;

  axil_if #(.ADDR_W(32), .DATA_W(32)) ab ();
  axil_if #(.ADDR_W(32), .DATA_W(32)) bb ();

  axil_init_seq #(
    .AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .CMD_NUM(3), .CMD_TABLE(TBL_A),
    .POLL_LIMIT(1024), .AUTO_START(1'b1)
  ) u_dut_a (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_i(a_start), .busy_o(a_busy),
    .done_o(a_done), .error_o(a_error), .err_idx_o(a_err_idx), .m_axil(ab)
  );

  axil_init_seq #(
    .AXIL_ADDR_WIDTH(32), .AXIL_DATA_WIDTH(32), .CMD_NUM(8), .CMD_TABLE(TBL_B),
    .POLL_LIMIT(16), .AUTO_START(1'b0)
  ) u_dut_b (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_i(b_start), .busy_o(b_busy),
    .done_o(b_done), .error_o(b_error), .err_idx_o(b_err_idx), .m_axil(bb)
  );

  // Zero-wait slave for DUT A: B response the cycle after the joint AW/W handshake
  logic        a_bvalid = 1'b0;
  logic [31:0] a_aw_q[$];
  logic [31:0] a_w_q[$];
  assign ab.awready = 1'b1;
  assign ab.wready  = 1'b1;
  assign ab.bvalid  = a_bvalid;
  assign ab.bresp   = 2'b00;
  assign ab.arready = 1'b1;
  assign ab.rvalid  = 1'b0;
  assign ab.rdata   = 32'h0;
  assign ab.rresp   = 2'b00;

  always @(posedge clk_i) begin
    if (ab.bvalid && ab.bready) a_bvalid <= 1'b0;
    if (ab.awvalid && ab.awready) a_aw_q.push_back(ab.awaddr);
    if (ab.wvalid && ab.wready) a_w_q.push_back(ab.wdata);
    if (ab.awvalid && ab.wvalid) a_bvalid <= 1'b1;
  end

  // Scripted slave for DUT B: wready lags wvalid by w_lat cycles, rdata 0 for the first zero_reads reads
  int          w_lat = 0, bad_wr = -1, zero_reads = 0;
  int          b_base = 0, ar_base = 0;
  int          b_wcnt = 0, ar_n = 0, split_n = 0, viol_n = 0, cyc = 0;
  logic        b_aw_got = 1'b0, b_w_got = 1'b0, b_bvalid = 1'b0, b_rvalid = 1'b0;
  logic [1:0]  b_bresp = 2'b00;
  logic [31:0] b_rdata = 32'h0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int          aw_rise_q[$];
  int          b_cyc_q[$];
  logic        p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic        split_pend = 1'b0;
  logic [31:0] p_awa = 32'h0, p_wd = 32'h0, p_ara = 32'h0;
  logic        b_aw_hs, b_w_hs;

  assign b_aw_hs    = bb.awvalid && bb.awready;
  assign b_w_hs     = bb.wvalid && bb.wready;
  assign bb.awready = 1'b1;
  assign bb.wready  = bb.wvalid && (b_wcnt >= w_lat);
  assign bb.bvalid  = b_bvalid;
  assign bb.bresp   = b_bresp;
  assign bb.arready = 1'b1;
  assign bb.rvalid  = b_rvalid;
  assign bb.rdata   = b_rdata;
  assign bb.rresp   = 2'b00;

  always @(posedge clk_i) begin
    cyc    <= cyc + 1;
    b_wcnt <= (bb.wvalid && !bb.wready) ? b_wcnt + 1 : 0;
    if (b_aw_hs) aw_q.push_back(bb.awaddr);
    if (b_w_hs) w_q.push_back(bb.wdata);
    if (bb.awvalid && !p_awv) aw_rise_q.push_back(cyc);
    if (bb.bvalid && bb.bready) begin
      b_bvalid <= 1'b0;
      b_cyc_q.push_back(cyc);
    end
    if ((b_aw_got || b_aw_hs) && (b_w_got || b_w_hs)) begin
      b_aw_got <= 1'b0;
      b_w_got  <= 1'b0;
      b_bvalid <= 1'b1;
      b_bresp  <= (b_cyc_q.size() - b_base == bad_wr) ? 2'b10 : 2'b00;
    end else begin
      if (b_aw_hs) b_aw_got <= 1'b1;
      if (b_w_hs)  b_w_got  <= 1'b1;
    end
    if (bb.rvalid && bb.rready) b_rvalid <= 1'b0;
    if (bb.arvalid && bb.arready) begin
      b_rvalid <= 1'b1;
      b_rdata  <= (ar_n - ar_base < zero_reads) ? 32'h0 : 32'h3;
      ar_n     <= ar_n + 1;
    end
    split_pend <= b_aw_hs && !b_w_hs;
    if (split_pend && !bb.awvalid && bb.wvalid) split_n <= split_n + 1;
    // A valid that dropped or whose payload moved without a handshake
    if ((p_awv && !p_awr && (!bb.awvalid || bb.awaddr != p_awa)) ||
        (p_wv  && !p_wr  && (!bb.wvalid  || bb.wdata  != p_wd))  ||
        (p_arv && !p_arr && (!bb.arvalid || bb.araddr != p_ara)))
      viol_n <= viol_n + 1;
    p_awv <= bb.awvalid; p_awr <= bb.awready; p_awa <= bb.awaddr;
    p_wv  <= bb.wvalid;  p_wr  <= bb.wready;  p_wd  <= bb.wdata;
    p_arv <= bb.arvalid; p_arr <= bb.arready; p_ara <= bb.araddr;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    b_start = 1'b1;
    @(negedge clk_i);
    b_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!b_done && !b_error && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    chk(tag, k < 3000, 1'b1);
  endtask

  int aw_base, rise_base, split_base, k;

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_b_busy", b_busy, 1'b0);
    chk("rst_b_done", b_done, 1'b0);
    chk("rst_b_error", b_error, 1'b0);
    chk("rst_b_err_idx", b_err_idx, 3'd0);
    chk("rst_b_valids", {bb.awvalid, bb.wvalid, bb.arvalid, bb.bready, bb.rready}, 5'b0);
    chk("rst_b_wstrb", bb.wstrb, 4'hF);
    chk("rst_a_busy", a_busy, 1'b0);
    arstn_i = 1'b1;

    // DUT A auto-starts; done expected within 10 cycles of reset release
    k = 0;
    while (!a_done && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("a_done_lat_le10", k <= 10, 1'b1);
    chk("a_error", a_error, 1'b0);
    chk("a_busy", a_busy, 1'b0);
    chk("a_aw_count", a_aw_q.size(), 2);
    chk("a_w_count", a_w_q.size(), 2);
    chk("a_aw0", a_aw_q[0], 32'h0000_0004);
    chk("a_aw1", a_aw_q[1], 32'h0001_0000);
    chk("a_w0", a_w_q[0], 32'h0000_01B2);
    chk("a_w1", a_w_q[1], 32'h0000_0005);
    chk("b_idle_no_autostart", {b_busy, bb.awvalid}, 2'b00);

    // Run 1: late wready, 3 failed polls, start pulse while busy must be ignored
    w_lat = 3; zero_reads = 3; bad_wr = -1;
    aw_base = aw_q.size(); rise_base = aw_rise_q.size(); b_base = b_cyc_q.size();
    ar_base = ar_n; split_base = split_n;
    pulse_start();
    chk("r1_busy", b_busy, 1'b1);
    repeat (5) @(negedge clk_i);
    pulse_start();
    wait_end("r1_timeout");
    chk("r1_done", b_done, 1'b1);
    chk("r1_error", b_error, 1'b0);
    chk("r1_busy_end", b_busy, 1'b0);
    chk("r1_aw_count", aw_q.size() - aw_base, 4);
    chk("r1_b_count", b_cyc_q.size() - b_base, 4);
    chk("r1_ar_count", ar_n - ar_base, 4);
    chk("r1_split_count", split_n - split_base, 4);
    chk("r1_aw0", aw_q[aw_base], 32'h0000_0004);
    chk("r1_aw2", aw_q[aw_base + 2], 32'h0000_000C);
    chk("r1_aw3", aw_q[aw_base + 3], 32'h0000_0020);
    chk("r1_w1", w_q[aw_base + 1], 32'h0000_0005);
    chk("r1_w3", w_q[aw_base + 3], 32'h0000_0055);
    chk("r1_delay_gap_ge101", aw_rise_q[rise_base + 3] - b_cyc_q[b_base + 2] >= 101, 1'b1);

    // Run 2: SLVERR on the third write (entry 2)
    w_lat = 0; zero_reads = 0; bad_wr = 2;
    aw_base = aw_q.size(); b_base = b_cyc_q.size(); ar_base = ar_n;
    pulse_start();
    chk("r2_done_cleared", b_done, 1'b0);
    wait_end("r2_timeout");
`ifdef AXIL_INIT_SEQ_RESP_CHECK_EN
    chk("r2_error", b_error, 1'b1);
    chk("r2_err_idx", b_err_idx, 3'd2);
    chk("r2_done", b_done, 1'b0);
    chk("r2_b_count", b_cyc_q.size() - b_base, 3);
`else
    chk("r2_error", b_error, 1'b0);
    chk("r2_done", b_done, 1'b1);
    chk("r2_b_count", b_cyc_q.size() - b_base, 4);
    chk("r2_ar_count", ar_n - ar_base, 1);
`endif
    chk("r2_busy", b_busy, 1'b0);

    // Run 3: poll never matches, limit 16; replays from entry 0
    bad_wr = -1; zero_reads = 1000;
    aw_base = aw_q.size(); b_base = b_cyc_q.size(); ar_base = ar_n;
    pulse_start();
    chk("r3_error_cleared", b_error, 1'b0);
    wait_end("r3_timeout");
    chk("r3_replay_aw0", aw_q[aw_base], 32'h0000_0004);
    chk("r3_error", b_error, 1'b1);
    chk("r3_err_idx", b_err_idx, 3'd5);
    chk("r3_done", b_done, 1'b0);
    chk("r3_ar_count", ar_n - ar_base, 16);
    repeat (20) @(negedge clk_i);
    chk("r3_no_more_ar", ar_n - ar_base, 16);
    chk("r3_busy", b_busy, 1'b0);
    chk("r3_valids_low", {bb.awvalid, bb.wvalid, bb.arvalid}, 3'b000);
    chk("protocol_violations", viol_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
